data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 95 +++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle data memory model answering MEM-stage loads/stores with a stall handshake.
// Ports: clk; reset (async, active-low); mem_read/mem_write request strobes;
//   addr (byte address) and write_data (store data); read_data (registered load data);
//   mem_ready (one-cycle pulse when the response completes); mem_busy (pipeline stall).
// Optional: define DMEM_BYTE_STROBE_EN to add byte_en[3:0], enabling per-byte-lane stores.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
`ifdef DMEM_BYTE_STROBE_EN
    input  logic [3:0]  byte_en,
`endif
    output logic [31:0] read_data,
    output logic        mem_ready,
    output logic        mem_busy
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAST = 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic          is_write;
    logic [AW-1:0] idx;
    logic [31:0]   wdata;
    logic [3:0]    ben;
    logic [31:0]   mem [DEPTH_WORDS];
    logic          req;
    logic          unused_addr;

    assign req         = mem_read | mem_write;
    assign mem_busy    = (state == IDLE && req) || state == WAIT;
    // Byte offset and bits above the array size are dropped, so addresses wrap.
    assign unused_addr = ^{addr[31:AW+2], addr[1:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_ready <= 1'b0;
            read_data <= '0;
            is_write  <= 1'b0;
            idx       <= '0;
            wdata     <= '0;
            ben       <= '0;
        end else begin
            mem_ready <= 1'b0;
            case (state)
                IDLE: if (req) begin
                    // A simultaneous read+write is treated as a write.
                    is_write <= mem_write;
                    idx      <= addr[AW+1:2];
                    wdata    <= write_data;
`ifdef DMEM_BYTE_STROBE_EN
                    ben      <= byte_en;
`else
                    ben      <= 4'hF;
`endif
                    cnt      <= '0;
                    if (WAIT_STATES == 0) begin
                        state     <= RESP;
                        mem_ready <= 1'b1;
                        if (!mem_write) read_data <= mem[addr[AW+1:2]];
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: if (cnt == LAST) begin
                    state     <= RESP;
                    mem_ready <= 1'b1;
                    if (!is_write) read_data <= mem[idx];
                end else begin
                    cnt <= cnt + 4'd1;
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Array has no reset; the store commits on the edge leaving RESP, so a reset
    // during the request forces IDLE first and the store never lands.
    always_ff @(posedge clk) begin
        if (state == RESP && is_write)
            for (int b = 0; b < 4; b++)
                if (ben[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
endmodule
